// File: rtl/qram_rr_arbiter.sv
// qram_rr_arbiter
// Two-requester round-robin arbiter in front of a single quad-lane RAM port.
// Ownership moves between requesters through a small FSM. The owner keeps the
// port for up to MAX_BURST granted cycles while the other requester waits, and
// is handed over directly (no idle bubble) when it stops requesting or when its
// burst budget is exhausted.
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   rN_req/wen/addr/four      requester N command (N = 0, 1)
//   rN_din_a..d               requester N write data lanes
//   rN_gnt                    access issued to the RAM this cycle
//   rN_rvalid                 read data on rN_dout_a..d valid this cycle
//   rN_dout_a..d              RAM read data, broadcast to both requesters
//   ram_ren/wen/addr/four     RAM command
//   ram_din_a..d              RAM write data lanes
//   ram_dout_a..d             RAM read data, valid one cycle after ram_ren
module qram_rr_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              r0_req,
    input  logic              r0_wen,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r0_four,
    input  logic [DATA_W-1:0] r0_din_a,
    input  logic [DATA_W-1:0] r0_din_b,
    input  logic [DATA_W-1:0] r0_din_c,
    input  logic [DATA_W-1:0] r0_din_d,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_dout_a,
    output logic [DATA_W-1:0] r0_dout_b,
    output logic [DATA_W-1:0] r0_dout_c,
    output logic [DATA_W-1:0] r0_dout_d,
    input  logic              r1_req,
    input  logic              r1_wen,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic              r1_four,
    input  logic [DATA_W-1:0] r1_din_a,
    input  logic [DATA_W-1:0] r1_din_b,
    input  logic [DATA_W-1:0] r1_din_c,
    input  logic [DATA_W-1:0] r1_din_d,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_dout_a,
    output logic [DATA_W-1:0] r1_dout_b,
    output logic [DATA_W-1:0] r1_dout_c,
    output logic [DATA_W-1:0] r1_dout_d,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_four,
    output logic [DATA_W-1:0] ram_din_a,
    output logic [DATA_W-1:0] ram_din_b,
    output logic [DATA_W-1:0] ram_din_c,
    output logic [DATA_W-1:0] ram_din_d,
    input  logic [DATA_W-1:0] ram_dout_a,
    input  logic [DATA_W-1:0] ram_dout_b,
    input  logic [DATA_W-1:0] ram_dout_c,
    input  logic [DATA_W-1:0] ram_dout_d
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [8:0] MAX_B = 9'(MAX_BURST);

    state_t     state;
    logic       last;
    logic [7:0] cnt;
    logic       vld0_p1;
    logic       vld1_p1;

    logic [8:0] cnt_inc;
    logic       burst_done;
    logic [7:0] cnt_sat;

    always_comb begin
        cnt_inc    = {1'b0, cnt} + 9'd1;
        burst_done = (cnt_inc >= MAX_B);
        cnt_sat    = burst_done ? MAX_B[7:0] : cnt_inc[7:0];
    end

    // Grants are masked while RST is high so that the reset cycle itself never
    // issues an access, even if the state still shows an owner.
    assign r0_gnt = (state == OWN0) && r0_req && !RST;
    assign r1_gnt = (state == OWN1) && r1_req && !RST;

    // The masking keeps a read that was granted just before reset from
    // returning rvalid during the reset cycle.
    assign r0_rvalid = vld0_p1 && !RST;
    assign r1_rvalid = vld1_p1 && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= 8'd0;
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
        end else begin
            vld0_p1 <= r0_gnt && !r0_wen;
            vld1_p1 <= r1_gnt && !r1_wen;
            case (state)
                IDLE: begin
                    // Tie goes to whichever requester did not own last.
                    if (r0_req && (!r1_req || last)) begin
                        state <= OWN0;
                        last  <= 1'b0;
                        cnt   <= 8'd0;
                    end else if (r1_req) begin
                        state <= OWN1;
                        last  <= 1'b1;
                        cnt   <= 8'd0;
                    end
                end
                OWN0: begin
                    if (r0_req && !(burst_done && r1_req)) begin
                        cnt <= cnt_sat;
                    end else if (r1_req) begin
                        state <= OWN1;
                        last  <= 1'b1;
                        cnt   <= 8'd0;
                    end else begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end
                end
                OWN1: begin
                    if (r1_req && !(burst_done && r0_req)) begin
                        cnt <= cnt_sat;
                    end else if (r0_req) begin
                        state <= OWN0;
                        last  <= 1'b0;
                        cnt   <= 8'd0;
                    end else begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // RAM command mux: driven only by the granted requester, zero otherwise.
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_four  = 1'b0;
        ram_din_a = '0;
        ram_din_b = '0;
        ram_din_c = '0;
        ram_din_d = '0;
        if (r0_gnt) begin
            ram_ren   = !r0_wen;
            ram_wen   = r0_wen;
            ram_addr  = r0_addr;
            ram_four  = r0_four;
            ram_din_a = r0_din_a;
            ram_din_b = r0_din_b;
            ram_din_c = r0_din_c;
            ram_din_d = r0_din_d;
        end else if (r1_gnt) begin
            ram_ren   = !r1_wen;
            ram_wen   = r1_wen;
            ram_addr  = r1_addr;
            ram_four  = r1_four;
            ram_din_a = r1_din_a;
            ram_din_b = r1_din_b;
            ram_din_c = r1_din_c;
            ram_din_d = r1_din_d;
        end
    end

    assign r0_dout_a = ram_dout_a;
    assign r0_dout_b = ram_dout_b;
    assign r0_dout_c = ram_dout_c;
    assign r0_dout_d = ram_dout_d;
    assign r1_dout_a = ram_dout_a;
    assign r1_dout_b = ram_dout_b;
    assign r1_dout_c = ram_dout_c;
    assign r1_dout_d = ram_dout_d;

endmodule

// File: doc/qram_rr_arbiter.md
QRAM_RR_ARBITER -- requirements
Module: qram_rr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, RAM word address width.
REQ-002 SHALL have parameter DATA_W, default 32, width of one RAM lane; four lanes a..d.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum consecutive grant cycles while the other requester waits (range 1..255).
REQ-004 SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports rN_req  in  1  requester N (N=0,1) wants an access this cycle.
REQ-007 SHALL have ports rN_wen  in  1  1=write, 0=read, qualified by rN_req.
REQ-008 SHALL have ports rN_addr  in  ADDR_W, rN_four  in  1 (quad access), rN_din_a..d  in  DATA_W each.
REQ-009 SHALL have ports rN_gnt  out  1  access issued to RAM this cycle.
REQ-010 SHALL have ports rN_rvalid  out  1  read data for N valid on rN_dout_a..d this cycle.
REQ-011 SHALL have ports rN_dout_a..d  out  DATA_W  copy of ram_dout_a..d (broadcast to both).
REQ-012 SHALL have ports ram_ren, ram_wen  out  1; ram_addr  out  ADDR_W; ram_four  out  1; ram_din_a..d  out  DATA_W.
REQ-013 SHALL have port ram_dout_a..d  in  DATA_W, valid one cycle after ram_ren.

Function
REQ-014 SHALL implement FSM states IDLE, OWN0, OWN1, one-hot or encoded, registered.
REQ-015 SHALL keep register last (1 bit) = last owner; lower priority goes to last.
REQ-016 IDLE: no req -> IDLE; one req -> OWN of that requester; both -> OWN of !last.
REQ-017 SHALL assert rN_gnt = (state==OWNN) & rN_req, combinationally; never both gnt high.
REQ-018 Arbitration latency SHALL be exactly one cycle from first req in IDLE to gnt.
REQ-019 While rN_gnt: ram_ren = !rN_wen, ram_wen = rN_wen, ram_addr/four/din = requester N values.
REQ-020 With no gnt: ram_ren = ram_wen = 0; ram_addr, ram_four, ram_din SHALL be 0.
REQ-021 SHALL count granted cycles in burst counter cnt (8 bits), cleared on each ownership change.
REQ-022 OWNN, rN_req=1, cnt+1 < MAX_BURST or other req=0 -> stay OWNN, cnt saturates at MAX_BURST.
REQ-023 OWNN, rN_req=1, cnt+1 >= MAX_BURST and other req=1 -> next state OWN(other) directly; the current cycle's access is still granted.
REQ-024 OWNN, rN_req=0: other req=1 -> OWN(other); else -> IDLE; no gnt this cycle.
REQ-025 On every transition into OWNN, last SHALL load N.
REQ-026 rN_rvalid SHALL be registered: 1 in cycle t+1 iff rN_gnt & !rN_wen in cycle t.
REQ-027 Writes SHALL produce no rvalid; a read followed by a write next cycle still yields rvalid for the read.
REQ-028 Handover SHALL lose no cycle of throughput between owners only via REQ-023/024 direct transitions (no IDLE bubble).
REQ-029 Requester inputs changing while not granted SHALL have no effect on RAM outputs.

Reset
REQ-030 RST=1 at an edge SHALL force state=IDLE, last=1 (r0 preferred first), cnt=0, r0_rvalid=r1_rvalid=0.
REQ-031 During RST cycle and cycle after, gnt, ram_ren, ram_wen SHALL be 0; a read in flight at reset SHALL never return rvalid.

Verification
REQ-032 Reset, r0_req and r1_req rise same cycle -> r0_gnt next cycle, r1_gnt never concurrent.
REQ-033 MAX_BURST=4, both hold req -> gnt pattern r0 x4, r1 x4, r0 x4, no idle cycle between.
REQ-034 r1 alone read addr 0x0010 four=1 -> ram_ren=1 addr 0x0010 in gnt cycle, r1_rvalid=1 next cycle with ram_dout_a..d passed, r0_rvalid=0.
REQ-035 r0 write addr 0x00FF din_a=0xDEADBEEF -> ram_wen=1 for one cycle, no rvalid; r0_req drop, r1 waiting -> OWN1 next cycle.
REQ-036 RST asserted the cycle after a granted read -> rvalid stays 0, state IDLE, next simultaneous req goes to r0.
REQ-037 Random req/wen traffic 10k cycles -> never dual gnt, every granted read yields exactly one rvalid one cycle later, no requester starved beyond MAX_BURST+1 cycles.
